// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: byte-enable codes, FSM states
// and the captured request record.
package brq_dmem_pkg;

   localparam logic [2:0] BE_B0  = 3'b000;
   localparam logic [2:0] BE_B1  = 3'b001;
   localparam logic [2:0] BE_B2  = 3'b010;
   localparam logic [2:0] BE_B3  = 3'b011;
   localparam logic [2:0] BE_HLO = 3'b100;
   localparam logic [2:0] BE_HHI = 3'b101;
   localparam logic [2:0] BE_W   = 3'b110;
   localparam logic [2:0] BE_ILL = 3'b111;

   // Address field is held zero-extended so range checks work for any AddrWidth <= 32.
   localparam int DMEM_REQ_AW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic                   we;
      logic [DMEM_REQ_AW-1:0] addr;
      logic [2:0]             byte_en;
      logic [31:0]            wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store stage (master) and the responder (slave).
// Defining DMEM_ERR_EN adds the rsp_err response flag.
interface dmem_responder_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 15
);
   // A request transfers on a rising edge where req_valid & req_ready; the master holds
   // every req_* field stable until then. rsp_valid is a one-cycle strobe, no back-pressure.
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [AddrWidth-1:0] req_addr;
   logic [2:0]           req_byte_en;
   logic [DataWidth-1:0] req_wdata;
   logic                 rsp_valid;
   logic [DataWidth-1:0] rsp_rdata;
   logic                 busy;
`ifdef DMEM_ERR_EN
   logic                 rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_byte_en, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, busy, rsp_err
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_byte_en, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, busy, rsp_err
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_byte_en, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_byte_en, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, busy
   );
`endif
endinterface

// File: rtl/dmem_lane_merge.sv
// Turns a byte-enable code and right-justified store data into a lane mask and
// lane-aligned write word. Code 111 yields an empty mask.
module dmem_lane_merge
   import brq_dmem_pkg::*;
(
   input  logic [2:0]  code_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  mask_o,
   output logic [31:0] data_o
);

   always_comb begin
      mask_o = 4'b0000;
      data_o = 32'h0;
      case (code_i)
         BE_B0, BE_B1, BE_B2, BE_B3: begin
            mask_o = 4'b0001 << code_i[1:0];
            data_o = {24'h0, wdata_i[7:0]} << {code_i[1:0], 3'b000};
         end
         BE_HLO: begin
            mask_o = 4'b0011;
            data_o = {16'h0, wdata_i[15:0]};
         end
         BE_HHI: begin
            mask_o = 4'b1100;
            data_o = {wdata_i[15:0], 16'h0};
         end
         BE_W: begin
            mask_o = 4'b1111;
            data_o = wdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-wide data RAM responder with programmable wait states and lane-merged stores.
// Defining DMEM_ERR_EN flags illegal codes and out-of-range addresses on rsp_err.
module dmem_responder
   import brq_dmem_pkg::*;
#(
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 15,
   parameter int Depth      = 4096,
   parameter int WaitCycles = 0
) (
   input  logic             brq_clk,
   input  logic             brq_rst,
   dmem_responder_if.slave  bus,
   output state_e           dbg_state_o
);

   localparam int IdxW = $clog2(Depth);

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   dmem_req_t              req_q, req_d, live_req, acc_req;
   logic [DataWidth-1:0]   rdata_q, rdata_d;
   logic [DataWidth-1:0]   ram [Depth];
   logic [AddrWidth-1:0]   addr_in;
   logic [IdxW-1:0]        acc_idx;
   logic [3:0]             lane_mask;
   logic [31:0]            lane_data;
   logic                   accept, enter_resp, acc_err, ram_we;

   assign bus.req_ready = (state_q != WAIT);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.busy      = (state_q == WAIT);
   assign bus.rsp_rdata = rdata_q;
   assign dbg_state_o   = state_q;

   assign accept  = bus.req_valid & bus.req_ready;
   assign addr_in = bus.req_addr;

   always_comb begin
      live_req         = '0;
      live_req.we      = bus.req_we;
      live_req.addr    = DMEM_REQ_AW'(addr_in);
      live_req.byte_en = bus.req_byte_en;
      live_req.wdata   = bus.req_wdata;
   end

   // Without wait states the RAM edge is the accept edge itself, so use the live request.
   assign acc_req = (WaitCycles == 0) ? live_req : req_q;
   assign acc_idx = acc_req.addr[IdxW-1:0];

`ifdef DMEM_ERR_EN
   logic err_q, err_d;
   assign acc_err     = (acc_req.byte_en == BE_ILL) || (acc_req.addr >= DMEM_REQ_AW'(Depth));
   assign bus.rsp_err = err_q;
`else
   logic unused_hi_addr;
   assign acc_err        = 1'b0;
   assign unused_hi_addr = ^acc_req.addr[DMEM_REQ_AW-1:IdxW];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (accept) begin
               req_d = live_req;
               if (WaitCycles > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WaitCycles - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP);
   assign ram_we     = enter_resp & acc_req.we & ~acc_err & ~brq_rst;

   always_comb begin
      rdata_d = rdata_q;
      if (enter_resp) rdata_d = (acc_req.we || acc_err) ? '0 : ram[acc_idx];
   end

`ifdef DMEM_ERR_EN
   always_comb begin
      err_d = err_q;
      if (enter_resp) err_d = acc_err;
   end
`endif

   dmem_lane_merge u_lane_merge (
      .code_i  (acc_req.byte_en),
      .wdata_i (acc_req.wdata),
      .mask_o  (lane_mask),
      .data_o  (lane_data)
   );

   always_ff @(posedge brq_clk or posedge brq_rst) begin
      if (brq_rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         rdata_q <= '0;
`ifdef DMEM_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
`ifdef DMEM_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge brq_clk) begin
      if (ram_we) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_mask[k]) ram[acc_idx][8*k +: 8] <= lane_data[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states, one with three.
// Honours DMEM_ERR_EN when the build defines it.
`timescale 1ns/1ps
module tb_dmem_responder;
   import brq_dmem_pkg::*;

   localparam int DEPTH = 4096;

   typedef struct packed {
      logic [31:0] rd;
      logic        er;
      logic [31:0] cyc;
   } exp_t;

   typedef struct {
      logic        we;
      int          addr;
      logic [2:0]  code;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   // clock / reset
   logic brq_clk = 1'b0;
   always #5 brq_clk = ~brq_clk;
   logic rst0, rst1;
   int   cyc = 0;
   always @(posedge brq_clk) cyc <= cyc + 1;

   logic [1:0]       vld, we_s, rdy, rv, bsy, er;
   logic [1:0][14:0] addr_s;
   logic [1:0][2:0]  code_s;
   logic [1:0][31:0] wd_s, rd;
   state_e           st0, st1;

   dmem_responder_if #(.DataWidth(32), .AddrWidth(15)) if0 ();
   dmem_responder_if #(.DataWidth(32), .AddrWidth(15)) if1 ();

   assign if0.req_valid = vld[0];  assign if1.req_valid = vld[1];
   assign if0.req_we = we_s[0];    assign if1.req_we = we_s[1];
   assign if0.req_addr = addr_s[0]; assign if1.req_addr = addr_s[1];
   assign if0.req_byte_en = code_s[0]; assign if1.req_byte_en = code_s[1];
   assign if0.req_wdata = wd_s[0]; assign if1.req_wdata = wd_s[1];
   assign rdy = {if1.req_ready, if0.req_ready};
   assign rv  = {if1.rsp_valid, if0.rsp_valid};
   assign bsy = {if1.busy, if0.busy};
   assign rd  = {if1.rsp_rdata, if0.rsp_rdata};
`ifdef DMEM_ERR_EN
   assign er  = {if1.rsp_err, if0.rsp_err};
`else
   assign er  = 2'b00;
`endif

   dmem_responder #(.DataWidth(32), .AddrWidth(15), .Depth(DEPTH), .WaitCycles(0)) u_dut0 (
      .brq_clk(brq_clk), .brq_rst(rst0), .bus(if0), .dbg_state_o(st0));
   dmem_responder #(.DataWidth(32), .AddrWidth(15), .Depth(DEPTH), .WaitCycles(3)) u_dut1 (
      .brq_clk(brq_clk), .brq_rst(rst1), .bus(if1), .dbg_state_o(st1));

   // scoreboard and reference model
   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   logic [31:0] mdl [2][DEPTH];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [2:0] code,
                                             input logic [31:0] wd);
      logic [31:0] r;
      int k;
      r = old;
      k = int'(code);
      if (k < 4)      r[k*8 +: 8] = wd[7:0];
      else if (k == 4) r[15:0]    = wd[15:0];
      else if (k == 5) r[31:16]   = wd[15:0];
      else if (k == 6) r          = wd;
      return r;
   endfunction

   task automatic model_access(input int d, input logic we, input int addr, input logic [2:0] code,
                               input logic [31:0] wd, output logic [31:0] rdv, output logic erv);
      int idx;
      idx = addr % DEPTH;
      erv = 1'b0;
`ifdef DMEM_ERR_EN
      erv = (code == 3'b111) || (addr >= DEPTH);
`endif
      rdv = 32'h0;
      if (!erv) begin
         if (we) mdl[d][idx] = ref_merge(mdl[d][idx], code, wd);
         else    rdv = mdl[d][idx];
      end
   endtask

   // driver: called in the low clock phase, returns one negedge after the accept edge
   task automatic issue(input int d, input logic we, input int addr, input logic [2:0] code,
                        input logic [31:0] wd, input logic have_exp, input logic [31:0] exp_rd,
                        input logic exp_er);
      exp_t        e;
      logic [31:0] mrd;
      logic        mer;
      int          n;
      vld[d] = 1'b1; we_s[d] = we; addr_s[d] = 15'(addr); code_s[d] = code; wd_s[d] = wd;
      n = 0;
      while (!rdy[d] && n < 100) begin
         @(negedge brq_clk);
         n++;
      end
      if (!rdy[d]) begin
         chk($sformatf("accept_timeout_d%0d", d), {31'h0, rdy[d]}, 32'h1);
         vld[d] = 1'b0;
         return;
      end
      model_access(d, we, addr, code, wd, mrd, mer);
      e.rd  = have_exp ? exp_rd : mrd;
      e.er  = have_exp ? exp_er : mer;
      e.cyc = 32'(cyc + 1 + (d == 0 ? 0 : 3));
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      @(posedge brq_clk);
      @(negedge brq_clk);
   endtask

   task automatic take_rsp(input int d);
      exp_t e;
      int   sz;
      sz = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (sz == 0) begin
         chk($sformatf("unexpected_rsp_d%0d", d), {31'h0, rv[d]}, 32'h0);
      end else begin
         if (d == 0) e = exp_q0.pop_front();
         else        e = exp_q1.pop_front();
         chk($sformatf("rdata_d%0d", d), rd[d], e.rd);
         chk($sformatf("rsp_cycle_d%0d", d), 32'(cyc), e.cyc);
`ifdef DMEM_ERR_EN
         chk($sformatf("rsp_err_d%0d", d), {31'h0, er[d]}, {31'h0, e.er});
`endif
      end
   endtask

   always @(negedge brq_clk) begin
      if (!rst0 && rv[0]) take_rsp(0);
      if (!rst1 && rv[1]) take_rsp(1);
   end

   task automatic chk_reset_outputs(input int d);
      chk($sformatf("rst_ready_d%0d", d), {31'h0, rdy[d]}, 32'h1);
      chk($sformatf("rst_rsp_valid_d%0d", d), {31'h0, rv[d]}, 32'h0);
      chk($sformatf("rst_busy_d%0d", d), {31'h0, bsy[d]}, 32'h0);
      chk($sformatf("rst_rdata_d%0d", d), rd[d], 32'h0);
      chk($sformatf("rst_state_d%0d", d), {30'h0, (d == 0) ? st0 : st1}, {30'h0, IDLE});
`ifdef DMEM_ERR_EN
      chk($sformatf("rst_err_d%0d", d), {31'h0, er[d]}, 32'h0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   vec_t        tbl [14];
   logic        bad;
   logic        err_build;
   int          n;

   initial begin
      err_build = 1'b0;
`ifdef DMEM_ERR_EN
      err_build = 1'b1;
`endif
      vld = '0; we_s = '0; addr_s = '0; code_s = '0; wd_s = '0;
      rst0 = 1'b1; rst1 = 1'b1;
      repeat (2) @(negedge brq_clk);
      chk_reset_outputs(0);
      chk_reset_outputs(1);
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge brq_clk);

      // lane-merge table, issued back to back on the zero-wait instance
      tbl[0]  = '{1'b1, 5, 3'd6, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b0, 5, 3'd6, 32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1'b1, 5, 3'd2, 32'h000000A5, 32'h0};
      tbl[3]  = '{1'b0, 5, 3'd6, 32'h0,        32'hDEA5BEEF};
      tbl[4]  = '{1'b1, 5, 3'd5, 32'h00001234, 32'h0};
      tbl[5]  = '{1'b0, 5, 3'd6, 32'h0,        32'h1234BEEF};
      tbl[6]  = '{1'b1, 5, 3'd0, 32'hFFFFFF77, 32'h0};
      tbl[7]  = '{1'b0, 5, 3'd6, 32'h0,        32'h1234BE77};
      tbl[8]  = '{1'b1, 5, 3'd4, 32'hFFFFCAFE, 32'h0};
      tbl[9]  = '{1'b0, 5, 3'd6, 32'h0,        32'h1234CAFE};
      tbl[10] = '{1'b1, 5, 3'd3, 32'h0000009A, 32'h0};
      tbl[11] = '{1'b0, 5, 3'd6, 32'h0,        32'h9A34CAFE};
      tbl[12] = '{1'b1, 5, 3'd1, 32'h00000011, 32'h0};
      tbl[13] = '{1'b0, 5, 3'd6, 32'h0,        32'h9A3411FE};
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("tbl_ready_%0d", i), {31'h0, rdy[0]}, 32'h1);
         issue(0, tbl[i].we, tbl[i].addr, tbl[i].code, tbl[i].wd, 1'b1, tbl[i].exp_rd, 1'b0);
      end
      vld[0] = 1'b0;

      // out-of-range address and illegal code
      issue(0, 1'b1, 9, 3'd6, 32'h11111111, 1'b1, 32'h0, 1'b0);
      issue(0, 1'b1, DEPTH + 9, 3'd6, 32'h00000055, 1'b1, 32'h0, err_build);
      issue(0, 1'b0, 9, 3'd6, 32'h0, 1'b1, err_build ? 32'h11111111 : 32'h00000055, 1'b0);
      issue(0, 1'b0, 5, 3'd7, 32'h0, 1'b1, err_build ? 32'h0 : 32'h9A3411FE, err_build);
      issue(0, 1'b1, 5, 3'd7, 32'hFFFFFFFF, 1'b1, 32'h0, err_build);
      issue(0, 1'b0, 5, 3'd6, 32'h0, 1'b1, 32'h9A3411FE, 1'b0);
      vld[0] = 1'b0;

      // wait-state timing on the three-wait instance, with an ignored request during WAIT
      issue(1, 1'b1, 3, 3'd6, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
      vld[1] = 1'b0;
      repeat (5) @(negedge brq_clk);
      issue(1, 1'b0, 3, 3'd6, 32'h0, 1'b0, 32'h0, 1'b0);
      vld[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 15'd3; code_s[1] = 3'd6; wd_s[1] = 32'hFFFFFFFF;
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("wait_busy_T%0d", i), {31'h0, bsy[1]}, 32'h1);
         chk($sformatf("wait_ready_T%0d", i), {31'h0, rdy[1]}, 32'h0);
         chk($sformatf("wait_rsp_T%0d", i), {31'h0, rv[1]}, 32'h0);
         @(negedge brq_clk);
      end
      vld[1] = 1'b0;
      chk("resp_valid_T4", {31'h0, rv[1]}, 32'h1);
      chk("resp_busy_T4", {31'h0, bsy[1]}, 32'h0);
      chk("resp_ready_T4", {31'h0, rdy[1]}, 32'h1);
      @(negedge brq_clk);
      issue(1, 1'b0, 3, 3'd6, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
      vld[1] = 1'b0;

      // reset during WAIT drops a pending store
      issue(1, 1'b1, 7, 3'd6, 32'h0, 1'b0, 32'h0, 1'b0);
      vld[1] = 1'b0;
      repeat (5) @(negedge brq_clk);
      vld[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 15'd7; code_s[1] = 3'd6; wd_s[1] = 32'hFFFFFFFF;
      chk("rstseq_ready", {31'h0, rdy[1]}, 32'h1);
      @(posedge brq_clk);
      @(negedge brq_clk);
      vld[1] = 1'b0;
      chk("rstseq_busy", {31'h0, bsy[1]}, 32'h1);
      @(negedge brq_clk);
      rst1 = 1'b1;
      #1;
      chk_reset_outputs(1);
      @(negedge brq_clk);
      rst1 = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         @(negedge brq_clk);
         if (rv[1]) bad = 1'b1;
      end
      chk("no_rsp_after_rst", {31'h0, bad}, 32'h0);
      issue(1, 1'b0, 7, 3'd6, 32'h0, 1'b1, 32'h0, 1'b0);
      vld[1] = 1'b0;

      // randomized traffic against the reference model
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 16; a++) issue(d, 1'b1, a, 3'd6, $urandom, 1'b0, 32'h0, 1'b0);
         for (int i = 0; i < 150; i++) begin
            int          ra;
            logic [2:0]  rc;
            ra = $urandom_range(0, 15) + (($urandom_range(0, 7) == 0) ? DEPTH : 0);
            rc = 3'($urandom_range(0, 7));
            issue(d, 1'($urandom_range(0, 1)), ra, rc, $urandom, 1'b0, 32'h0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
               vld[d] = 1'b0;
               repeat ($urandom_range(1, 2)) @(negedge brq_clk);
            end
         end
         vld[d] = 1'b0;
      end

      n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
         @(negedge brq_clk);
         n++;
      end
      chk("drain_q0", 32'(exp_q0.size()), 32'h0);
      chk("drain_q1", 32'(exp_q1.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
